// File: rtl/sdrd_sector_packer.sv
// sdrd_sector_packer: SD CMD17 block receiver packing 512 data bytes into sixteen 256-bit words with CRC16 check
module sdrd_sector_packer #(
   parameter int unsigned TOKEN_TIMEOUT = 1024,
   parameter bit          CRC_CHECK     = 1'b1
) (
   input  logic         CLK,
   input  logic         RST_X,
   input  logic         SECT_START,
   input  logic [7:0]   SPI_BYTE_IN,
   input  logic         SPI_BYTE_VALID,
   output logic [255:0] PRM_OUT,
   output logic         PRM_VALID,
   output logic [3:0]   PRM_WORD_IDX,
   output logic         SECT_DONE,
   output logic         SECT_ERR,
   output logic         BUSY
);
   typedef enum logic [2:0] {IDLE, WAIT_TOKEN, DATA, CRC_HI, CRC_LO, FINISH} state_t;
   localparam logic [15:0] TMO = TOKEN_TIMEOUT[15:0];
   state_t       state_q;
   logic [15:0]  tcnt_q, tcnt_d, crc_q, crc_d;
   logic [8:0]   bcnt_q;
   logic [7:0]   crc_hi_q;
   logic [255:0] lane_q, lane_d, prm_out_q;
   logic [3:0]   prm_idx_q;
   logic         prm_valid_q, done_q, err_q, busy_q;
   assign PRM_OUT      = prm_out_q;
   assign PRM_VALID    = prm_valid_q;
   assign PRM_WORD_IDX = prm_idx_q;
   assign SECT_DONE    = done_q;
   assign SECT_ERR     = err_q;
   assign BUSY         = busy_q;
   // CRC16-CCITT (0x1021), MSB-first, one byte per accepted data byte
   always_comb begin
      lane_d = lane_q;
      lane_d[{bcnt_q[4:0], 3'b000} +: 8] = SPI_BYTE_IN;
      crc_d = crc_q ^ {SPI_BYTE_IN, 8'h00};
      for (int i = 0; i < 8; i++)
         crc_d = crc_d[15] ? ({crc_d[14:0], 1'b0} ^ 16'h1021) : {crc_d[14:0], 1'b0};
      tcnt_d = tcnt_q + 16'd1;
   end
   always_ff @(posedge CLK or negedge RST_X)
      if (!RST_X) begin
         state_q     <= IDLE;
         tcnt_q      <= '0;
         crc_q       <= '0;
         bcnt_q      <= '0;
         crc_hi_q    <= '0;
         lane_q      <= '0;
         prm_out_q   <= '0;
         prm_idx_q   <= '0;
         prm_valid_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         prm_valid_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         case (state_q)
            IDLE:
               if (SECT_START) begin
                  state_q <= WAIT_TOKEN;
                  tcnt_q  <= '0;
                  bcnt_q  <= '0;
                  crc_q   <= '0;
                  busy_q  <= 1'b1;
               end
            WAIT_TOKEN:
               if (SPI_BYTE_VALID) begin
                  if (SPI_BYTE_IN == 8'hFE)
                     state_q <= DATA;
                  else if (SPI_BYTE_IN == 8'hFF && tcnt_d != TMO)
                     tcnt_q <= tcnt_d;
                  else begin
                     state_q <= FINISH;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end
            DATA:
               if (SPI_BYTE_VALID) begin
                  lane_q <= lane_d;
                  crc_q  <= crc_d;
                  bcnt_q <= bcnt_q + 9'd1;
                  if (&bcnt_q[4:0]) begin
                     prm_out_q   <= lane_d;
                     prm_valid_q <= 1'b1;
                     prm_idx_q   <= bcnt_q[8:5];
                  end
                  if (&bcnt_q)
                     state_q <= CRC_HI;
               end
            CRC_HI:
               if (SPI_BYTE_VALID) begin
                  crc_hi_q <= SPI_BYTE_IN;
                  state_q  <= CRC_LO;
               end
            CRC_LO:
               if (SPI_BYTE_VALID) begin
                  state_q <= FINISH;
                  done_q  <= 1'b1;
                  err_q   <= CRC_CHECK && ({crc_hi_q, SPI_BYTE_IN} != crc_q);
                  busy_q  <= 1'b0;
               end
            default:
               state_q <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_sdrd_sector_packer.sv
// tb_sdrd_sector_packer: directed bench for the SD sector packer
module tb_sdrd_sector_packer;
   logic         CLK = 1'b0, RST_X = 1'b1, SECT_START = 1'b0, SPI_BYTE_VALID = 1'b0;
   logic [7:0]   SPI_BYTE_IN = 8'h00;
   logic [255:0] PRM_OUT, n_prm_out;
   logic         PRM_VALID, SECT_DONE, SECT_ERR, BUSY, n_prm_valid, n_done, n_err, n_busy;
   logic [3:0]   PRM_WORD_IDX, n_idx;
   int           checks = 0, errors = 0, cyc = 0, due = -1, nw = 0, ndone = 0;
   logic [7:0]   data [512];
   logic [255:0] words [16], golden [16];
   sdrd_sector_packer #(.TOKEN_TIMEOUT(8), .CRC_CHECK(1'b1)) dut (
      .CLK(CLK), .RST_X(RST_X), .SECT_START(SECT_START), .SPI_BYTE_IN(SPI_BYTE_IN),
      .SPI_BYTE_VALID(SPI_BYTE_VALID), .PRM_OUT(PRM_OUT), .PRM_VALID(PRM_VALID),
      .PRM_WORD_IDX(PRM_WORD_IDX), .SECT_DONE(SECT_DONE), .SECT_ERR(SECT_ERR), .BUSY(BUSY));
   sdrd_sector_packer #(.TOKEN_TIMEOUT(1024), .CRC_CHECK(1'b0)) dut_n (
      .CLK(CLK), .RST_X(RST_X), .SECT_START(SECT_START), .SPI_BYTE_IN(SPI_BYTE_IN),
      .SPI_BYTE_VALID(SPI_BYTE_VALID), .PRM_OUT(n_prm_out), .PRM_VALID(n_prm_valid),
      .PRM_WORD_IDX(n_idx), .SECT_DONE(n_done), .SECT_ERR(n_err), .BUSY(n_busy));
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, got, exp);
      end
   endtask
   // PRM_VALID must appear exactly in the cycle after each 32nd data byte is accepted
   always @(negedge CLK) begin
      chk("pv_time", PRM_VALID, cyc == due);
      if (PRM_VALID) begin
         chk("idx", PRM_WORD_IDX, nw[3:0]);
         if (nw < 16) words[nw] = PRM_OUT;
         nw++;
      end
      if (SECT_DONE) ndone++;
   end
   function automatic logic [15:0] crc_of();
      logic [15:0] c;
      logic        fb;
      c = 16'h0000;
      for (int i = 0; i < 512; i++)
         for (int b = 7; b >= 0; b--) begin
            fb = c[15] ^ data[i][b];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
         end
      return c;
   endfunction
   task automatic put(input logic [7:0] b);
      SPI_BYTE_IN    = b;
      SPI_BYTE_VALID = 1'b1;
      @(posedge CLK); #1;
      SPI_BYTE_VALID = 1'b0;
   endtask
   task automatic gap(input int maxgap);
      repeat (maxgap > 0 ? $urandom_range(maxgap, 0) : 0) begin
         @(posedge CLK); #1;
      end
   endtask
   task automatic start();
      @(posedge CLK); #1;
      nw = 0;
      ndone = 0;
      SECT_START = 1'b1;
      @(posedge CLK); #1;
      SECT_START = 1'b0;
      chk("busy", BUSY, 1);
   endtask
   task automatic fill_index();
      for (int i = 0; i < 512; i++) data[i] = i[7:0];
   endtask
   task automatic sector(input int nff, input int maxgap, input logic [15:0] crc_tx,
                         input logic exp_err, input int dup_at);
      logic [255:0] e;
      start();
      repeat (nff) begin
         put(8'hFF);
         gap(maxgap);
      end
      put(8'hFE);
      gap(maxgap);
      for (int i = 0; i < 512; i++) begin
         SECT_START = (i == dup_at);
         put(data[i]);
         SECT_START = 1'b0;
         if (i % 32 == 31) due = cyc;
         gap(maxgap);
      end
      put(crc_tx[15:8]);
      gap(maxgap);
      put(crc_tx[7:0]);
      chk("done", SECT_DONE, 1);
      chk("err", SECT_ERR, exp_err);
      chk("busy_fin", BUSY, 0);
      chk("nwords", nw, 16);
      for (int w = 0; w < 16; w++) begin
         for (int k = 0; k < 32; k++) e[8*k +: 8] = data[32*w + k];
         chk("word", words[w], e);
      end
      chk("hold", PRM_OUT, e);
      chk("hold_idx", PRM_WORD_IDX, 15);
   endtask
   task automatic outs_zero(input string tag);
      chk({tag, "_out"}, PRM_OUT, 0);
      chk({tag, "_pv"}, PRM_VALID, 0);
      chk({tag, "_idx"}, PRM_WORD_IDX, 0);
      chk({tag, "_done"}, SECT_DONE, 0);
      chk({tag, "_err"}, SECT_ERR, 0);
      chk({tag, "_busy"}, BUSY, 0);
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog");
      $fatal(1);
   end
   initial begin
      #2 RST_X = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      outs_zero("rst");
      RST_X = 1'b1;
      // index pattern, correct CRC
      fill_index();
      sector(3, 0, crc_of(), 1'b0, -1);
      chk("w0_lo", words[0][7:0], 8'h00);
      chk("w0_hi", words[0][255:248], 8'h1F);
      chk("w15_lo", words[15][7:0], 8'hE0);
      chk("n_done", n_done, 1);
      chk("n_err", n_err, 0);
      golden = words;
      // start during the FINISH cycle is ignored
      SECT_START = 1'b1;
      @(posedge CLK); #1;
      SECT_START = 1'b0;
      chk("fin_start", BUSY, 0);
      @(posedge CLK); #1;
      chk("fin_start2", BUSY, 0);
      // all-zero data: CRC 0x0000 good, 0x0001 bad unless checking disabled
      for (int i = 0; i < 512; i++) data[i] = 8'h00;
      sector(0, 0, 16'h0000, 1'b0, -1);
      sector(0, 0, 16'h0001, 1'b1, -1);
      chk("n_nocheck_done", n_done, 1);
      chk("n_nocheck_err", n_err, 0);
      // token timeout at 8 x 0xFF
      start();
      repeat (7) put(8'hFF);
      chk("to_early", SECT_DONE, 0);
      chk("to_busy", BUSY, 1);
      put(8'hFF);
      chk("to_done", SECT_DONE, 1);
      chk("to_err", SECT_ERR, 1);
      chk("to_busy_fin", BUSY, 0);
      chk("to_nopv", nw, 0);
      RST_X = 1'b0;
      @(posedge CLK); #1;
      RST_X = 1'b1;
      fill_index();
      sector(7, 0, crc_of(), 1'b0, -1);
      // data error token
      start();
      put(8'h05);
      chk("tok_done", SECT_DONE, 1);
      chk("tok_err", SECT_ERR, 1);
      chk("tok_busy", BUSY, 0);
      @(posedge CLK); #1;
      chk("tok_idle", BUSY, 0);
      // start and a byte together: the 0xFE is dropped, so 0x05 becomes the token
      nw = 0;
      SECT_START = 1'b1;
      put(8'hFE);
      SECT_START = 1'b0;
      chk("same_busy", BUSY, 1);
      put(8'h05);
      chk("same_done", SECT_DONE, 1);
      chk("same_err", SECT_ERR, 1);
      // second start mid-sector must not disturb it
      sector(0, 0, crc_of(), 1'b0, 100);
      // random stalls reproduce the gap-free words
      sector(2, 5, crc_of(), 1'b0, -1);
      for (int w = 0; w < 16; w++) chk("gap_word", words[w], golden[w]);
      // reset after word 7 aborts without SECT_DONE
      start();
      put(8'hFE);
      for (int i = 0; i < 256; i++) begin
         put(data[i]);
         if (i % 32 == 31) due = cyc;
      end
      @(negedge CLK); #1;
      chk("pre_rst_nw", nw, 8);
      RST_X = 1'b0;
      #1;
      outs_zero("mid");
      @(posedge CLK); #1;
      RST_X = 1'b1;
      chk("mid_nodone", ndone, 0);
      sector(3, 0, crc_of(), 1'b0, -1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
